// File: rtl/mem_responder.sv
// Byte-addressed big-endian RAM responder with a MOV/MOC four-phase handshake and programmable wait states.
// Optional build macro MEM_PRELOAD_EN adds the INIT_FILE parameter.
`timescale 1ns/1ps

module mem_responder #(
   parameter int ADDR_WIDTH  = 9,
   parameter int WAIT_STATES = 2
`ifdef MEM_PRELOAD_EN
   ,
   parameter string INIT_FILE = "mem_init.hex"
`endif
) (
   input  logic                  main_clk,
   input  logic                  reset,
   input  logic                  mov,
   input  logic                  rw,
   input  logic [1:0]            dl,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           data_in,
   output logic [31:0]           data_out,
   output logic                  moc,
   output logic                  mem_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    rw_q, rw_d;
   logic [1:0]              dl_q, dl_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [31:0]             data_out_q, data_out_d;
   logic                    moc_q, moc_d;
   logic                    mem_err_q, mem_err_d;

   logic [7:0]              mem [DEPTH];
   logic [ADDR_WIDTH-1:0]   addr1, addr2, addr3;
   logic                    legal;
   logic [31:0]             rdata;

   // Request legality and big-endian read assembly from the latched request.
   always_comb begin
      addr1 = addr_q + ADDR_WIDTH'(1);
      addr2 = addr_q + ADDR_WIDTH'(2);
      addr3 = addr_q + ADDR_WIDTH'(3);
      legal = 1'b0;
      rdata = 32'h0;
      case (dl_q)
         2'b00: begin
            legal = 1'b1;
            rdata = {24'h0, mem[addr_q]};
         end
         2'b01: begin
            legal = ~addr_q[0];
            rdata = {16'h0, mem[addr_q], mem[addr1]};
         end
         2'b10: begin
            legal = (addr_q[1:0] == 2'b00);
            rdata = {mem[addr_q], mem[addr1], mem[addr2], mem[addr3]};
         end
         default: begin
            legal = 1'b0;
            rdata = 32'h0;
         end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rw_d       = rw_q;
      dl_d       = dl_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      data_out_d = data_out_q;
      moc_d      = moc_q;
      mem_err_d  = mem_err_q;
      case (state_q)
         ST_IDLE: begin
            if (mov) begin
               rw_d    = rw;
               dl_d    = dl;
               addr_d  = address;
               wdata_d = data_in;
               cnt_d   = 4'h0;
               state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'(WAIT_STATES - 1)) begin
               state_d = ST_ACCESS;
            end else begin
               cnt_d = cnt_q + 4'h1;
            end
         end
         ST_ACCESS: begin
            moc_d     = 1'b1;
            mem_err_d = ~legal;
            if (!legal) begin
               data_out_d = 32'h0;
            end else if (rw_q) begin
               data_out_d = rdata;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (!mov) begin
               moc_d     = 1'b0;
               mem_err_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge main_clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'h0;
         rw_q       <= 1'b0;
         dl_q       <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= 32'h0;
         data_out_q <= 32'h0;
         moc_q      <= 1'b0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rw_q       <= rw_d;
         dl_q       <= dl_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         data_out_q <= data_out_d;
         moc_q      <= moc_d;
         mem_err_q  <= mem_err_d;
      end
   end

   // The array is never cleared; a reset on the ACCESS edge suppresses the write.
   always_ff @(posedge main_clk) begin
      if (!reset && state_q == ST_ACCESS && legal && !rw_q) begin
         case (dl_q)
            2'b00: mem[addr_q] <= wdata_q[7:0];
            2'b01: begin
               mem[addr_q] <= wdata_q[15:8];
               mem[addr1]  <= wdata_q[7:0];
            end
            2'b10: begin
               mem[addr_q] <= wdata_q[31:24];
               mem[addr1]  <= wdata_q[23:16];
               mem[addr2]  <= wdata_q[15:8];
               mem[addr3]  <= wdata_q[7:0];
            end
            default: ;
         endcase
      end
   end

   assign data_out = data_out_q;
   assign moc      = moc_q;
   assign mem_err  = mem_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: two instances (2 and 0 wait states) against a byte-array reference model.
`timescale 1ns/1ps

module tb_mem_responder;

   logic        main_clk = 1'b0;
   logic        reset    = 1'b1;
   logic        mov_a    = 1'b0;
   logic        mov_b    = 1'b0;
   logic        rw       = 1'b0;
   logic [1:0]  dl       = 2'b00;
   logic [8:0]  address  = 9'h0;
   logic [31:0] data_in  = 32'h0;
   logic [31:0] dout_a, dout_b;
   logic        moc_a, moc_b, err_a, err_b;

   int          sel = 0;
   logic        cur_moc, cur_err;
   logic [31:0] cur_dout;

   int          checks   = 0;
   int          failures = 0;

   logic [7:0]  ref_mem [2][512];
   logic [31:0] exp_dout [2];

   always #5 main_clk = ~main_clk;

   mem_responder #(.ADDR_WIDTH(9), .WAIT_STATES(2)) dut (
      .main_clk(main_clk), .reset(reset), .mov(mov_a), .rw(rw), .dl(dl),
      .address(address), .data_in(data_in), .data_out(dout_a), .moc(moc_a), .mem_err(err_a)
   );

   mem_responder #(.ADDR_WIDTH(9), .WAIT_STATES(0)) dut0 (
      .main_clk(main_clk), .reset(reset), .mov(mov_b), .rw(rw), .dl(dl),
      .address(address), .data_in(data_in), .data_out(dout_b), .moc(moc_b), .mem_err(err_b)
   );

   assign cur_moc  = (sel == 1) ? moc_b  : moc_a;
   assign cur_err  = (sel == 1) ? err_b  : err_a;
   assign cur_dout = (sel == 1) ? dout_b : dout_a;

   task automatic scramble();
      rw      = 1'($urandom);
      dl      = 2'($urandom);
      address = 9'($urandom);
      data_in = $urandom;
   endtask

   // One complete handshake; the model is updated from the request before it is issued.
   task automatic do_op(input int s, input logic r, input logic [1:0] l, input logic [8:0] a,
                        input logic [31:0] d, input int hold, input string name);
      int          n, ai, edges, exp_lat;
      logic        legal;
      logic [31:0] e;
      bit          done;
      n       = 1 << l;
      ai      = int'(a);
      legal   = (l != 2'b11) && ((ai % n) == 0);
      exp_lat = (s == 0) ? 4 : 2;
      if (!legal) begin
         exp_dout[s] = 32'h0;
      end else if (r) begin
         e = 32'h0;
         for (int k = 0; k < n; k++) e = (e << 8) | {24'h0, ref_mem[s][(ai + k) % 512]};
         exp_dout[s] = e;
      end else begin
         for (int k = 0; k < n; k++) ref_mem[s][(ai + k) % 512] = 8'(d >> (8 * (n - 1 - k)));
      end

      @(negedge main_clk);
      sel     = s;
      rw      = r;
      dl      = l;
      address = a;
      data_in = d;
      if (s == 1) mov_b = 1'b1; else mov_a = 1'b1;
      edges = 0;
      done  = 0;
      while (!done && edges < 40) begin
         @(posedge main_clk);
         #1;
         edges++;
         if (cur_moc) done = 1;
         else scramble();
      end
      checks++;
      if (!done) begin
         failures++;
         $display("[TB] FAIL %s timeout: moc=%0b after %0d edges, required 1", name, cur_moc, edges);
      end else if (edges != exp_lat) begin
         failures++;
         $display("[TB] FAIL %s latency: got %0d edges, required %0d", name, edges, exp_lat);
      end
      checks++;
      if (cur_err !== !legal) begin
         failures++;
         $display("[TB] FAIL %s mem_err: got %0b, required %0b", name, cur_err, !legal);
      end
      checks++;
      if (cur_dout !== exp_dout[s]) begin
         failures++;
         $display("[TB] FAIL %s data_out: got %h, required %h", name, cur_dout, exp_dout[s]);
      end

      for (int i = 0; i < hold; i++) begin
         scramble();
         @(posedge main_clk);
         #1;
         checks++;
         if (cur_moc !== 1'b1 || cur_dout !== exp_dout[s] || cur_err !== !legal) begin
            failures++;
            $display("[TB] FAIL %s hold%0d: moc=%0b err=%0b dout=%h, required moc=1 err=%0b dout=%h",
                     name, i, cur_moc, cur_err, cur_dout, !legal, exp_dout[s]);
         end
      end

      @(negedge main_clk);
      mov_a = 1'b0;
      mov_b = 1'b0;
      @(posedge main_clk);
      #1;
      checks++;
      if (cur_moc !== 1'b0 || cur_err !== 1'b0 || cur_dout !== exp_dout[s]) begin
         failures++;
         $display("[TB] FAIL %s release: moc=%0b err=%0b dout=%h, required moc=0 err=0 dout=%h",
                  name, cur_moc, cur_err, cur_dout, exp_dout[s]);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) begin
         @(negedge main_clk);
         mov_a = 1'($urandom);
         mov_b = 1'($urandom);
         scramble();
      end
      @(negedge main_clk);
      mov_a = 1'b0;
      mov_b = 1'b0;
      @(posedge main_clk);
      #1;
      checks++;
      if (moc_a !== 1'b0 || err_a !== 1'b0 || dout_a !== 32'h0) begin
         failures++;
         $display("[TB] FAIL reset_a: moc=%0b err=%0b dout=%h, required 0 0 0", moc_a, err_a, dout_a);
      end
      checks++;
      if (moc_b !== 1'b0 || err_b !== 1'b0 || dout_b !== 32'h0) begin
         failures++;
         $display("[TB] FAIL reset_b: moc=%0b err=%0b dout=%h, required 0 0 0", moc_b, err_b, dout_b);
      end
      @(negedge main_clk);
      reset = 1'b0;
      exp_dout[0] = 32'h0;
      exp_dout[1] = 32'h0;
   endtask

   task automatic test_word();
      do_op(0, 1'b0, 2'b10, 9'h010, 32'hDEADBEEF, 0, "word_wr");
      do_op(0, 1'b1, 2'b10, 9'h010, 32'h0, 0, "word_rd");
   endtask

   task automatic test_subword();
      do_op(0, 1'b1, 2'b00, 9'h011, 32'h0, 0, "byte_rd");
      do_op(0, 1'b1, 2'b01, 9'h012, 32'h0, 0, "half_rd");
      do_op(0, 1'b0, 2'b01, 9'h014, 32'h0000C3D4, 0, "half_wr");
      do_op(0, 1'b1, 2'b10, 9'h014, 32'h0, 0, "half_wr_chk");
   endtask

   task automatic test_illegal();
      do_op(0, 1'b1, 2'b10, 9'h013, 32'h0, 0, "word_misalign");
      do_op(0, 1'b1, 2'b01, 9'h011, 32'h0, 0, "half_misalign");
      do_op(0, 1'b0, 2'b10, 9'h020, 32'h0BADCAFE, 0, "pre_wr_020");
      do_op(0, 1'b0, 2'b11, 9'h020, 32'hFFFFFFFF, 0, "dl11_wr");
      do_op(0, 1'b1, 2'b10, 9'h020, 32'h0, 0, "dl11_chk");
      do_op(0, 1'b0, 2'b10, 9'h022, 32'h55555555, 0, "word_wr_misalign");
      do_op(0, 1'b1, 2'b10, 9'h020, 32'h0, 0, "misalign_wr_chk");
   endtask

   task automatic test_hold();
      do_op(0, 1'b0, 2'b10, 9'h080, 32'h11112222, 5, "hold_wr");
      do_op(0, 1'b1, 2'b10, 9'h080, 32'h0, 5, "hold_rd");
   endtask

   task automatic test_reset_mid_op();
      do_op(0, 1'b0, 2'b10, 9'h040, 32'hCAFEF00D, 0, "old_wr_040");
      do_op(0, 1'b1, 2'b10, 9'h040, 32'h0, 0, "old_rd_040");
      @(negedge main_clk);
      sel     = 0;
      rw      = 1'b0;
      dl      = 2'b10;
      address = 9'h040;
      data_in = 32'h12345678;
      mov_a   = 1'b1;
      @(posedge main_clk);
      @(negedge main_clk);
      reset = 1'b1;
      @(posedge main_clk);
      #1;
      checks++;
      if (moc_a !== 1'b0 || err_a !== 1'b0 || dout_a !== 32'h0) begin
         failures++;
         $display("[TB] FAIL mid_reset: moc=%0b err=%0b dout=%h, required 0 0 0", moc_a, err_a, dout_a);
      end
      @(negedge main_clk);
      reset = 1'b0;
      mov_a = 1'b0;
      exp_dout[0] = 32'h0;
      exp_dout[1] = 32'h0;
      do_op(0, 1'b1, 2'b10, 9'h040, 32'h0, 0, "mid_reset_chk");
   endtask

   task automatic test_ws0();
      do_op(1, 1'b0, 2'b00, 9'h1FF, 32'h000000A5, 0, "ws0_byte_wr");
      do_op(1, 1'b1, 2'b00, 9'h1FF, 32'h0, 0, "ws0_byte_rd");
      do_op(1, 1'b0, 2'b10, 9'h1FC, 32'h89ABCDEF, 1, "ws0_word_wr");
      do_op(1, 1'b1, 2'b01, 9'h1FE, 32'h0, 0, "ws0_half_top");
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++) do_op(0, 1'b0, 2'b10, 9'(9'h100 + 4 * i), $urandom, 0, "rnd_init_a");
      for (int i = 0; i < 4; i++)  do_op(1, 1'b0, 2'b10, 9'(9'h1F0 + 4 * i), $urandom, 0, "rnd_init_b");
      for (int i = 0; i < 40; i++) begin
         do_op(0, 1'($urandom), 2'($urandom_range(0, 3)), 9'(9'h100 + $urandom_range(0, 63)),
               $urandom, $urandom_range(0, 2), "rnd_a");
      end
      for (int i = 0; i < 15; i++) begin
         do_op(1, 1'($urandom), 2'($urandom_range(0, 3)), 9'(9'h1F0 + $urandom_range(0, 15)),
               $urandom, $urandom_range(0, 2), "rnd_b");
      end
   endtask

   initial begin
      exp_dout[0] = 32'h0;
      exp_dout[1] = 32'h0;
      test_reset();
      test_word();
      test_subword();
      test_illegal();
      test_hold();
      test_reset_mid_op();
      test_ws0();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
